fifo_counted: RTL and testbench

Parametrised synchronous FIFO with full-depth occupancy, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky protocol-violation flag. It is the general-purpose successor FIFO for all valid/ready and valid/yumi stream buffering in the systolic-array datapath, for example operand staging and result drain. Unlike the pointer-compare FIFO, it stores exactly `depth_p` entries, supports non-power-of-two depths, and reports occupancy.

---
 rtl/fifo_counted.sv | 99 +++++++++
 tb/tb_fifo_counted.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_counted.sv
// Synchronous FIFO holding exactly depth_p entries (any depth >= 2) with occupancy
// count, almost-full/almost-empty thresholds, synchronous flush and sticky underflow.
module fifo_counted #(
  parameter int width_p        = 8,
  parameter int depth_p        = 128,
  parameter int almost_full_p  = depth_p - 2,
  parameter int almost_empty_p = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             flush_i,
  output logic                             ready_o,
  input  logic                             valid_i,
  input  logic [width_p-1:0]               data_i,
  output logic                             valid_o,
  output logic [width_p-1:0]               data_o,
  input  logic                             yumi_i,
  output logic [$clog2(depth_p+1)-1:0]     count_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o,
  output logic                             underflow_o
);

  localparam int cnt_w_lp = $clog2(depth_p + 1);
  localparam int ptr_w_lp = $clog2(depth_p);

  localparam logic [cnt_w_lp-1:0] depth_cnt_lp = cnt_w_lp'(depth_p);
  localparam logic [cnt_w_lp-1:0] af_cnt_lp    = cnt_w_lp'(almost_full_p);
  localparam logic [cnt_w_lp-1:0] ae_cnt_lp    = cnt_w_lp'(almost_empty_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp  = ptr_w_lp'(depth_p - 1);

  logic [width_p-1:0]  mem_q [depth_p];
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                underflow_q, underflow_d;
  logic                push, pop, mem_we;

  // All handshake flags decode from the count register alone.
  always_comb begin
    ready_o        = (count_q != depth_cnt_lp);
    valid_o        = (count_q != '0);
    almost_full_o  = (count_q >= af_cnt_lp);
    almost_empty_o = (count_q <= ae_cnt_lp);
    underflow_o    = underflow_q;
    count_o        = count_q;
    data_o         = mem_q[rd_ptr_q];
  end

  always_comb begin
    push   = valid_i & ready_o;
    pop    = yumi_i & valid_o;
    mem_we = push & ~flush_i & ~reset_i;

    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (yumi_i & ~valid_o)
        underflow_d = 1'b1;
      if (push)
        wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
      if (pop)
        rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_w_lp'(1);
        2'b01:   count_d = count_q - cnt_w_lp'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; contents are meaningful only while counted.
  always_ff @(posedge clk_i) begin
    if (mem_we)
      mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_fifo_counted.sv
// Bench for fifo_counted (depth 5): directed vector table, streaming sequence and
// randomized traffic against a queue-based reference model.
module tb_fifo_counted;

  logic       clk = 1'b0;
  logic       reset_i, flush_i, valid_i, yumi_i;
  logic [7:0] data_i, data_o;
  logic       ready_o, valid_o, almost_full_o, almost_empty_o, underflow_o;
  logic [2:0] count_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_counted #(
    .width_p(8),
    .depth_p(5),
    .almost_full_p(4),
    .almost_empty_p(1)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .flush_i(flush_i),
    .ready_o(ready_o),
    .valid_i(valid_i),
    .data_i(data_i),
    .valid_o(valid_o),
    .data_o(data_o),
    .yumi_i(yumi_i),
    .count_o(count_o),
    .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o),
    .underflow_o(underflow_o)
  );

  typedef struct {
    logic       rst, fl, v;
    logic [7:0] d;
    logic       y;
    logic [2:0] cnt;
    logic       vo, ro, af, ae, uf, cd;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic fl, logic v, logic [7:0] d, logic y,
                              logic [2:0] cnt, logic vo, logic ro, logic af, logic ae,
                              logic uf, logic cd, logic [7:0] dat);
    vec_t r;
    r.rst = rst; r.fl = fl; r.v = v; r.d = d; r.y = y;
    r.cnt = cnt; r.vo = vo; r.ro = ro; r.af = af; r.ae = ae; r.uf = uf;
    r.cd = cd; r.dat = dat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic v,
                       input logic [7:0] d, input logic y);
    @(negedge clk);
    reset_i = rst; flush_i = fl; valid_i = v; data_i = d; yumi_i = y;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic       m_uf;

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; yumi_i = 1'b0; data_i = '0;

    // rst fl v  d      y   cnt vo ro af ae uf cd dat
    vecs.push_back(mk(1, 0, 1, 8'h55, 1, 0, 0, 1, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h66, 1, 0, 0, 1, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h10, 0, 1, 1, 1, 0, 1, 0, 1, 8'h10));
    vecs.push_back(mk(0, 0, 1, 8'h11, 0, 2, 1, 1, 0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 0, 1, 8'h12, 0, 3, 1, 1, 0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 0, 1, 8'h13, 0, 4, 1, 1, 1, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 0, 1, 8'h14, 0, 5, 1, 0, 1, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 0, 1, 8'h15, 0, 5, 1, 0, 1, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 4, 1, 1, 1, 0, 0, 1, 8'h11));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 1, 1, 0, 0, 0, 1, 8'h12));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 1, 1, 0, 0, 0, 1, 8'h13));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 1, 0, 1, 8'h14));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 0, 8'h00));
    // underflow, survives flush
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 0, 8'h00));
    // flush at count 3 with push and pop
    vecs.push_back(mk(0, 0, 1, 8'h20, 0, 1, 1, 1, 0, 1, 1, 1, 8'h20));
    vecs.push_back(mk(0, 0, 1, 8'h21, 0, 2, 1, 1, 0, 0, 1, 1, 8'h20));
    vecs.push_back(mk(0, 0, 1, 8'h22, 0, 3, 1, 1, 0, 0, 1, 1, 8'h20));
    vecs.push_back(mk(0, 1, 1, 8'h23, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'hAB, 0, 1, 1, 1, 0, 1, 1, 1, 8'hAB));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00));
    // full with simultaneous yumi: pop only, then push accepted
    vecs.push_back(mk(0, 0, 1, 8'h30, 0, 1, 1, 1, 0, 1, 0, 1, 8'h30));
    vecs.push_back(mk(0, 0, 1, 8'h31, 0, 2, 1, 1, 0, 0, 0, 1, 8'h30));
    vecs.push_back(mk(0, 0, 1, 8'h32, 0, 3, 1, 1, 0, 0, 0, 1, 8'h30));
    vecs.push_back(mk(0, 0, 1, 8'h33, 0, 4, 1, 1, 1, 0, 0, 1, 8'h30));
    vecs.push_back(mk(0, 0, 1, 8'h34, 0, 5, 1, 0, 1, 0, 0, 1, 8'h30));
    vecs.push_back(mk(0, 0, 1, 8'h35, 1, 4, 1, 1, 1, 0, 0, 1, 8'h31));
    vecs.push_back(mk(0, 0, 1, 8'h36, 0, 5, 1, 0, 1, 0, 0, 1, 8'h31));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 4, 1, 1, 1, 0, 0, 1, 8'h32));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 1, 1, 0, 0, 0, 1, 8'h33));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 1, 1, 0, 0, 0, 1, 8'h34));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 1, 0, 1, 8'h36));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 0, 8'h00));
    // push and pop together at count 1
    vecs.push_back(mk(0, 0, 1, 8'h40, 0, 1, 1, 1, 0, 1, 0, 1, 8'h40));
    vecs.push_back(mk(0, 0, 1, 8'h41, 1, 1, 1, 1, 0, 1, 0, 1, 8'h41));
    vecs.push_back(mk(0, 0, 1, 8'h42, 1, 1, 1, 1, 0, 1, 0, 1, 8'h42));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 0, 8'h00));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].y);
      chk($sformatf("vec%0d count", i), 32'(count_o), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d valid", i), 32'(valid_o), 32'(vecs[i].vo));
      chk($sformatf("vec%0d ready", i), 32'(ready_o), 32'(vecs[i].ro));
      chk($sformatf("vec%0d almost_full", i), 32'(almost_full_o), 32'(vecs[i].af));
      chk($sformatf("vec%0d almost_empty", i), 32'(almost_empty_o), 32'(vecs[i].ae));
      chk($sformatf("vec%0d underflow", i), 32'(underflow_o), 32'(vecs[i].uf));
      if (vecs[i].cd)
        chk($sformatf("vec%0d data", i), 32'(data_o), 32'(vecs[i].dat));
    end

    // Streaming from count 2 across several pointer wraps.
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 8'h00, 0);
    drive(0, 0, 1, 8'h01, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 8'(i + 2), 1);
      chk($sformatf("stream%0d count", i), 32'(count_o), 32'd2);
      chk($sformatf("stream%0d data", i), 32'(data_o), 32'(8'(i + 1)));
    end

    // Randomized traffic against a queue model.
    drive(1, 0, 0, 8'h00, 0);
    q.delete();
    m_uf = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic       r_rst, r_fl, r_v, r_y, m_push, m_pop;
      logic [7:0] r_d;
      r_rst = ($urandom_range(0, 99) < 2);
      r_fl  = ($urandom_range(0, 99) < 3);
      r_v   = ($urandom_range(0, 99) < 55);
      r_y   = (q.size() != 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 4);
      r_d   = 8'($urandom);
      m_push = r_v && (q.size() < 5);
      m_pop  = r_y && (q.size() > 0);
      if (r_rst) begin
        q.delete();
        m_uf = 1'b0;
      end else if (r_fl) begin
        q.delete();
      end else begin
        if (r_y && q.size() == 0) m_uf = 1'b1;
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(r_d);
      end
      drive(r_rst, r_fl, r_v, r_d, r_y);
      chk("rand count", 32'(count_o), 32'(q.size()));
      chk("rand valid", 32'(valid_o), 32'(q.size() != 0));
      chk("rand ready", 32'(ready_o), 32'(q.size() != 5));
      chk("rand almost_full", 32'(almost_full_o), 32'(q.size() >= 4));
      chk("rand almost_empty", 32'(almost_empty_o), 32'(q.size() <= 1));
      chk("rand underflow", 32'(underflow_o), 32'(m_uf));
      if (q.size() != 0)
        chk("rand data", 32'(data_o), 32'(q[0]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
